// File: rtl/am_similarity_search.sv
// ---------------------------------------------------------------------------
// am_similarity_search
//   Associative-memory search for the sparse HDC classifier. Each class
//   hypervector is scored by its overlap with the stored query, which is
//   popcount(query & class). The index of the highest score is reported with
//   a one-cycle valid strobe. On a tie the lower class index wins.
//
// Ports
//   clk              rising-edge clock
//   nrst             asynchronous active-low reset
//   start            search request, only sampled in IDLE
//   busy             high from the cycle after an accepted start until the
//                    cycle in which inference_valid is high
//   rd_en            read strobe to the AM RAM and the query buffer
//   class_addr       class currently being read
//   word_addr        word within the hypervector (shared by AM and query)
//   am_rd_data       class word, 1-cycle read latency
//   query_rd_data    query word, 1-cycle read latency
//   class_inference  winning class index
//   best_score       winning overlap count
//   inference_valid  single-cycle strobe when the results update
//
// State  | meaning
// IDLE   | waiting for start; running best and counters held cleared
// FETCH  | one read per cycle for the WORDS words of the current class
// DRAIN  | no read; the last word of the class is accumulated
// CMP    | accumulator compared against the running best
// DONE   | results published, valid strobe issued on leaving
// ---------------------------------------------------------------------------
module am_similarity_search #(
  parameter  int NUM_CLASSES = 26,
  parameter  int HV_DIM      = 1024,
  parameter  int WORD_W      = 64,
  localparam int WORDS       = HV_DIM / WORD_W,
  localparam int WA_W        = (WORDS > 1) ? $clog2(WORDS) : 1,
  localparam int SC_W        = $clog2(HV_DIM + 1)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  output logic              busy,
  output logic              rd_en,
  output logic [4:0]        class_addr,
  output logic [WA_W-1:0]   word_addr,
  input  logic [WORD_W-1:0] am_rd_data,
  input  logic [WORD_W-1:0] query_rd_data,
  output logic [4:0]        class_inference,
  output logic [SC_W-1:0]   best_score,
  output logic              inference_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_CMP,
    S_DONE
  } state_t;

  localparam logic [WA_W-1:0] LAST_WORD  = WA_W'(WORDS - 1);
  localparam logic [4:0]      LAST_CLASS = 5'(NUM_CLASSES - 1);

  state_t            state_q;
  logic              busy_q;
  logic              rd_en_q;
  logic              rvalid_q;
  logic [4:0]        class_q;
  logic [WA_W-1:0]   word_q;
  logic [SC_W-1:0]   acc_q;
  logic [SC_W-1:0]   acc_d;
  logic [SC_W-1:0]   run_score_q;
  logic [4:0]        run_idx_q;
  logic              first_q;
  logic [4:0]        class_inf_q;
  logic [SC_W-1:0]   best_score_q;
  logic              valid_q;

  logic [WORD_W-1:0] overlap_word;
  logic [SC_W-1:0]   word_pop;

  assign overlap_word = am_rd_data & query_rd_data;

  always_comb begin
    word_pop = '0;
    for (int i = 0; i < WORD_W; i++) begin
      word_pop = word_pop + SC_W'(overlap_word[i]);
    end
    acc_d = acc_q + word_pop;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      rvalid_q     <= 1'b0;
      class_q      <= '0;
      word_q       <= '0;
      acc_q        <= '0;
      run_score_q  <= '0;
      run_idx_q    <= '0;
      first_q      <= 1'b1;
      class_inf_q  <= '0;
      best_score_q <= '0;
      valid_q      <= 1'b0;
    end else begin
      valid_q  <= 1'b0;
      // Read data arrives one cycle after the strobe that requested it.
      rvalid_q <= rd_en_q;
      if (rvalid_q) begin
        acc_q <= acc_d;
      end

      case (state_q)
        S_IDLE: begin
          class_q     <= '0;
          word_q      <= '0;
          acc_q       <= '0;
          run_score_q <= '0;
          run_idx_q   <= '0;
          first_q     <= 1'b1;
          if (start) begin
            state_q <= S_FETCH;
            busy_q  <= 1'b1;
            rd_en_q <= 1'b1;
          end
        end

        S_FETCH: begin
          if (word_q == LAST_WORD) begin
            word_q  <= '0;
            rd_en_q <= 1'b0;
            state_q <= S_DRAIN;
          end else begin
            word_q <= word_q + 1'b1;
          end
        end

        S_DRAIN: begin
          state_q <= S_CMP;
        end

        S_CMP: begin
          // Strict compare keeps the lowest index on a tie.
          if (first_q || (acc_q > run_score_q)) begin
            run_score_q <= acc_q;
            run_idx_q   <= class_q;
          end
          first_q <= 1'b0;
          acc_q   <= '0;
          if (class_q == LAST_CLASS) begin
            state_q <= S_DONE;
          end else begin
            class_q <= class_q + 1'b1;
            rd_en_q <= 1'b1;
            state_q <= S_FETCH;
          end
        end

        S_DONE: begin
          class_inf_q  <= run_idx_q;
          best_score_q <= run_score_q;
          valid_q      <= 1'b1;
          busy_q       <= 1'b0;
          class_q      <= '0;
          state_q      <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          rd_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy            = busy_q;
  assign rd_en           = rd_en_q;
  assign class_addr      = class_q;
  assign word_addr       = word_q;
  assign class_inference = class_inf_q;
  assign best_score      = best_score_q;
  assign inference_valid = valid_q;

endmodule

// File: tb/tb_am_similarity_search.sv
module tb_am_similarity_search;

  localparam int NUM   = 4;
  localparam int HV    = 256;
  localparam int W     = 64;
  localparam int WORDS = HV / W;
  localparam int WA_W  = 2;
  localparam int SC_W  = 9;
  localparam int LAT   = NUM * (WORDS + 2) + 1;

  logic            clk = 1'b0;
  logic            nrst = 1'b0;
  logic            start = 1'b0;
  logic            busy;
  logic            rd_en;
  logic [4:0]      class_addr;
  logic [WA_W-1:0] word_addr;
  logic [W-1:0]    am_rd_data = '0;
  logic [W-1:0]    query_rd_data = '0;
  logic [4:0]      class_inference;
  logic [SC_W-1:0] best_score;
  logic            inference_valid;

  logic [HV-1:0] am_hv [NUM];
  logic [HV-1:0] q_hv;

  int n_cmp = 0;
  int n_err = 0;

  am_similarity_search #(
    .NUM_CLASSES(NUM),
    .HV_DIM(HV),
    .WORD_W(W)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .start(start),
    .busy(busy),
    .rd_en(rd_en),
    .class_addr(class_addr),
    .word_addr(word_addr),
    .am_rd_data(am_rd_data),
    .query_rd_data(query_rd_data),
    .class_inference(class_inference),
    .best_score(best_score),
    .inference_valid(inference_valid)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories with one cycle of latency.
  always @(posedge clk) begin
    if (rd_en) begin
      if (int'(class_addr) < NUM) am_rd_data <= am_hv[int'(class_addr)][int'(word_addr)*W +: W];
      else                        am_rd_data <= '0;
      query_rd_data <= q_hv[int'(word_addr)*W +: W];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: argmax of overlap counts, first maximum wins.
  task automatic model(output int ei, output int es);
    int s;
    es = -1;
    ei = 0;
    for (int c = 0; c < NUM; c++) begin
      s = $countones(am_hv[c] & q_hv);
      if (s > es) begin
        es = s;
        ei = c;
      end
    end
  endtask

  function automatic logic [HV-1:0] ones_low(input int k);
    logic [HV-1:0] v;
    v = '0;
    for (int i = 0; i < k; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [HV-1:0] rand_hv();
    logic [HV-1:0] v;
    for (int i = 0; i < HV/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic set_overlaps(input int o0, input int o1, input int o2, input int o3);
    q_hv     = {HV{1'b1}};
    am_hv[0] = ones_low(o0);
    am_hv[1] = ones_low(o1);
    am_hv[2] = ones_low(o2);
    am_hv[3] = ones_low(o3);
  endtask

  // Entered and left at a falling edge. The start edge is edge 0, and the
  // sample at t is taken in the cycle that follows edge t.
  task automatic run_search(input string tag, input bit chain, input bit pulse_busy);
    int ei, es, ph;
    model(ei, es);
    start = 1'b1;
    @(posedge clk);
    for (int t = 0; t <= LAT; t++) begin
      @(negedge clk);
      start = (pulse_busy && (t == 4 || t == 11)) || (chain && t == LAT);
      chk({tag, "_busy"},  32'(busy), 32'(t < LAT));
      chk({tag, "_valid"}, 32'(inference_valid), 32'(t == LAT));
      ph = t % (WORDS + 2);
      if (t < LAT - 1 && ph < WORDS) begin
        chk({tag, "_rd_en"}, 32'(rd_en), 32'd1);
        chk({tag, "_class_addr"}, 32'(class_addr), 32'(t / (WORDS + 2)));
        chk({tag, "_word_addr"}, 32'(word_addr), 32'(ph));
      end else begin
        chk({tag, "_rd_en_gap"}, 32'(rd_en), 32'd0);
      end
      if (t == LAT) begin
        chk({tag, "_class"}, 32'(class_inference), 32'(ei));
        chk({tag, "_score"}, 32'(best_score), 32'(es));
      end
    end
    if (!chain) begin
      start = 1'b0;
      @(negedge clk);
      chk({tag, "_valid_once"}, 32'(inference_valid), 32'd0);
      chk({tag, "_class_hold"}, 32'(class_inference), 32'(ei));
      chk({tag, "_score_hold"}, 32'(best_score), 32'(es));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    chk({tag, "_class_addr"}, 32'(class_addr), 32'd0);
    chk({tag, "_word_addr"}, 32'(word_addr), 32'd0);
    chk({tag, "_class"}, 32'(class_inference), 32'd0);
    chk({tag, "_score"}, 32'(best_score), 32'd0);
    chk({tag, "_valid"}, 32'(inference_valid), 32'd0);
  endtask

  initial begin
    for (int c = 0; c < NUM; c++) am_hv[c] = '0;
    q_hv = '0;

    #1;
    chk_all_zero("reset");
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    set_overlaps(10, 40, 25, 3);
    run_search("unique", 1'b0, 1'b0);

    set_overlaps(7, 30, 30, 12);
    run_search("tie", 1'b0, 1'b0);

    for (int c = 0; c < NUM; c++) am_hv[c] = rand_hv();
    q_hv = '0;
    run_search("zero_query", 1'b0, 1'b0);

    for (int c = 0; c < NUM; c++) am_hv[c] = '0;
    am_hv[3] = {HV{1'b1}};
    q_hv     = {HV{1'b1}};
    run_search("full", 1'b0, 1'b0);

    set_overlaps(5, 17, 60, 33);
    run_search("start_busy", 1'b0, 1'b1);

    // Abort a search at cycle 10 after its start.
    for (int c = 0; c < NUM; c++) am_hv[c] = rand_hv();
    q_hv  = rand_hv();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    nrst = 1'b0;
    #1;
    chk_all_zero("abort");
    for (int t = 0; t < LAT + 5; t++) begin
      @(negedge clk);
      if (t == 3) nrst = 1'b1;
      chk("abort_no_valid", 32'(inference_valid), 32'd0);
    end

    run_search("restart_a", 1'b1, 1'b0);
    for (int c = 0; c < NUM; c++) am_hv[c] = rand_hv() & rand_hv();
    q_hv = rand_hv();
    run_search("restart_b", 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < NUM; c++) begin
        am_hv[c] = (r % 2 == 0) ? (rand_hv() & rand_hv()) : rand_hv();
      end
      q_hv = rand_hv();
      if (r == 5) am_hv[2] = am_hv[0];
      run_search($sformatf("rand%0d", r), 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/am_similarity_search.md
# am_similarity_search

Associative-memory search stage for the sparse HDC classifier. It scores a stored query hypervector against every class hypervector in the AM by overlap: popcount of (query AND class). It emits the argmax class index with a one-cycle valid strobe. Sits directly upstream of the accuracy tally: `class_inference` feeds its class input, and `inference_valid` drives its tally enable.

## Interface
- `NUM_CLASSES`, 26: classes searched, indices 0..NUM_CLASSES-1; range 2..32.
- `HV_DIM`, 1024: hypervector dimension in bits.
- `WORD_W`, 64: AM/query read word width; HV_DIM must be a multiple of WORD_W.
- Derived: WORDS = HV_DIM/WORD_W; WA_W = max(1, clog2(WORDS)); SC_W = clog2(HV_DIM+1).

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `nrst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a search; sampled only in IDLE.
- `busy`  out  1  high from the cycle after an accepted start until `inference_valid`.
- `rd_en`  out  1  read strobe to the AM RAM and the query buffer.
- `class_addr`  out  5  class being read.
- `word_addr`  out  WA_W  word within the hypervector; shared by the AM and query buffer.
- `am_rd_data`  in  WORD_W  class word; 1-cycle read latency.
- `query_rd_data`  in  WORD_W  query word; 1-cycle read latency.
- `class_inference`  out  5  winning class index.
- `best_score`  out  SC_W  winning overlap count.
- `inference_valid`  out  1  single-cycle strobe when results update.

## Operation
- States: IDLE, FETCH, DRAIN, CMP, DONE.
- IDLE:
  - `start`=1 moves to FETCH.
  - Clears class counter, word counter, accumulator, and running best. Running best starts at score 0, index 0, with the first-flag set.
- FETCH: `rd_en`=1 for WORDS consecutive cycles, with `word_addr` 0..WORDS-1 and `class_addr` = current class. After the last word, go to DRAIN.
- Accumulation: a 1-cycle delayed read-valid flag qualifies the data. When set, accumulator += popcount(am_rd_data & query_rd_data). The last word's data lands in DRAIN.
- DRAIN: `rd_en`=0; absorbs the final word. Then go to CMP.
- CMP: running best takes the accumulator and class index when the first-flag is set or accumulator > best. Comparison is strict, so ties keep the lowest index.
  - Afterwards: clear the first-flag and the accumulator.
  - If class = NUM_CLASSES-1, go to DONE; else increment class and return to FETCH.
- DONE:
  - Loads `class_inference`/`best_score` from the running best and pulses `inference_valid` for exactly one cycle.
  - Deasserts `busy` and returns to IDLE.
- Outputs hold their values until the next DONE.
- Accumulator width SC_W; it cannot overflow, since the maximum is HV_DIM.
- `start` while not in IDLE is ignored; it is not queued.
- Reset values: `busy`=0, `rd_en`=0, `class_addr`=0, `word_addr`=0, `class_inference`=0, `best_score`=0, `inference_valid`=0, state IDLE.
- Reset mid-search aborts immediately. No `inference_valid` is produced for the aborted search, and outputs return to 0.

## Timing
- `start` is sampled at edge 0 in IDLE; the first FETCH cycle follows.
- Per class: WORDS FETCH cycles + 1 DRAIN + 1 CMP = WORDS+2 cycles.
- `inference_valid` is high in the cycle beginning NUM_CLASSES*(WORDS+2)+1 edges after the start edge.
- Defaults: 26*(16+2)+1 = 469 cycles.
- `start` held high in the cycle after DONE (back in IDLE) begins a new search with no bubble beyond IDLE.
- The query buffer contents must stay stable while `busy`=1. This block does not check it.

## Test plan
Directed tests use NUM_CLASSES=4, HV_DIM=256, WORD_W=64, so WORDS=4 and latency = 25.

- **Unique maximum:** overlaps {10, 40, 25, 3} for classes 0..3.
  - Required: `inference_valid` 25 cycles after start, `class_inference`=1, `best_score`=40.
  - Check the `rd_en`/address sequence: 4 words per class, with gaps for DRAIN and CMP.
- **Tie:** overlaps {7, 30, 30, 12}. Required: `class_inference`=1, `best_score`=30 (lowest index wins).
- **All-zero query:** every overlap is 0. Required: `class_inference`=0, `best_score`=0, valid still pulses once.
- **Full-overlap boundary:** query and class 3 all-ones, other classes all-zero.
  - Required: `class_inference`=3, `best_score`=256. This exercises the maximum SC_W value with no wrap.
- **Start while busy:** pulse `start` at cycles 5 and 12 after the first start.
  - Required: exactly one valid at cycle 25, results unchanged, `busy` continuously high until then.
- **Reset and restart:**
  - Assert `nrst`=0 at cycle 10. Required: all outputs 0 immediately, no valid.
  - Restart, then a back-to-back start after DONE. Required: two valid pulses spaced 26 cycles apart with correct results.
